// File: rtl/button_poller.sv
// button_poller: Avalon-MM read initiator that polls the button port,
// debounces the 8-bit vector and turns stable presses into pending events.
// Optional feature macro: BUTTON_POLLER_IRQ_EN adds a registered irq output.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | poll counter running; waits POLL_DIV cycles between reads
// READ    | avm_read strobe asserted for exactly this cycle
// CAPTURE | read data valid; sample taken and debounce state updated
module button_poller #(
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic [7:0]  stable,
  output logic        event_valid,
  output logic [7:0]  event_data,
  input  logic        event_ready
`ifdef BUTTON_POLLER_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [15:0] POLL_LAST = 16'(POLL_DIV - 1);
  localparam logic [3:0]  DB_TARGET = 4'(DEBOUNCE);
  // Idle level of the buttons: nothing pressed.
  localparam logic [7:0]  REST_VAL  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_e;

  state_e      state_q, state_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [3:0]  dcount_q, dcount_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  stable_q, stable_d;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  press;
  logic [7:0]  sample;
  logic        accept;
  logic        unused_readdata;

  assign sample          = avm_readdata[7:0];
  assign unused_readdata = ^avm_readdata[31:8];
  assign accept          = event_valid & event_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      poll_cnt_q <= '0;
      dcount_q   <= '0;
      last_q     <= REST_VAL;
      stable_q   <= REST_VAL;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      dcount_q   <= dcount_d;
      last_q     <= last_d;
      stable_q   <= stable_d;
      pending_q  <= pending_d;
    end
  end

  // Poll sequencing: count in IDLE, one-cycle read, then capture.
  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    case (state_q)
      IDLE: begin
        if (poll_cnt_q == POLL_LAST) begin
          poll_cnt_d = '0;
          state_d    = READ;
        end else begin
          poll_cnt_d = poll_cnt_q + 16'd1;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Whole-vector debounce and press detection on accepted stable changes.
  always_comb begin
    dcount_d = dcount_q;
    last_d   = last_q;
    stable_d = stable_q;
    press    = '0;
    if (state_q == CAPTURE) begin
      if (sample == last_q) begin
        dcount_d = (dcount_q == 4'hF) ? dcount_q : dcount_q + 4'd1;
      end else begin
        dcount_d = 4'd1;
      end
      last_d = sample;
      if ((dcount_d >= DB_TARGET) && (sample != stable_q)) begin
        stable_d = sample;
        press    = (ACTIVE_LOW != 0) ? (stable_q & ~sample) : (~stable_q & sample);
      end
    end
  end

  // A press arriving in the accept cycle survives the clear.
  always_comb begin
    pending_d = (accept ? 8'h00 : pending_q) | press;
  end

  assign avm_address = 2'b00;
  assign avm_read    = (state_q == READ);
  assign stable      = stable_q;
  assign event_data  = pending_q;
  assign event_valid = |pending_q;

`ifdef BUTTON_POLLER_IRQ_EN
  logic irq_q;

  // Interrupt tracks the next pending value so it drops right after the emptying accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |pending_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_button_poller.sv
// Bench for button_poller: POLL_DIV=8, DEBOUNCE=2, ACTIVE_LOW=1.
// Expected press masks are queued by the stimulus; the monitor pops and
// compares them whenever the DUT hands over an event.
module tb_button_poller;

  localparam int POLL_DIV = 8;
  localparam int DEBOUNCE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic [7:0]  stable;
  logic        event_valid;
  logic [7:0]  event_data;
  logic        event_ready;
`ifdef BUTTON_POLLER_IRQ_EN
  logic        irq;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  button_poller #(
    .POLL_DIV  (POLL_DIV),
    .DEBOUNCE  (DEBOUNCE),
    .ACTIVE_LOW(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .avm_address (avm_address),
    .avm_read    (avm_read),
    .avm_readdata(avm_readdata),
    .stable      (stable),
    .event_valid (event_valid),
    .event_data  (event_data),
    .event_ready (event_ready)
`ifdef BUTTON_POLLER_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handed-over event must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_event: got %h, expected none", event_data);
      end else begin
        chk("event_data", {24'h0, event_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Wait for the next read strobe, serve data in the capture cycle (registered
  // slave), optionally accept during capture; returns just after the update edge.
  task automatic do_poll(input logic [31:0] data, input logic rdy_cap);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (avm_read) begin
        found = 1;
        break;
      end
    end
    chk("read_seen", {31'h0, found}, 32'h1);
    chk("avm_address", {30'h0, avm_address}, 32'h0);
    @(posedge clk); #1;
    chk("read_one_cycle", {31'h0, avm_read}, 32'h0);
    avm_readdata = data;
    event_ready  = rdy_cap;
    @(posedge clk); #1;
    event_ready  = 1'b0;
  endtask

  task automatic accept_one();
    event_ready = 1'b1;
    @(posedge clk); #1;
    event_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    reset        = 1'b1;
    event_ready  = 1'b0;
    avm_readdata = 32'h0000_00FF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avm_read", {31'h0, avm_read}, 32'h0);
    chk("rst_stable", {24'h0, stable}, 32'hFF);
    chk("rst_event_valid", {31'h0, event_valid}, 32'h0);
    chk("rst_event_data", {24'h0, event_data}, 32'h0);
`ifdef BUTTON_POLLER_IRQ_EN
    chk("rst_irq", {31'h0, irq}, 32'h0);
`endif
    reset = 1'b0;

    // Read strobe schedule: cycles 8, 18, 28 after reset release.
    for (int n = 1; n <= 29; n++) begin
      @(posedge clk); #1;
      chk("read_schedule", {31'h0, avm_read}, {31'h0, (n == 8 || n == 18 || n == 28)});
      chk("avm_address", {30'h0, avm_address}, 32'h0);
    end
    chk("idle_stable", {24'h0, stable}, 32'hFF);
    chk("idle_valid", {31'h0, event_valid}, 32'h0);

    // Bit0 pressed for two polls, consumer not ready.
    do_poll(32'h0000_00FE, 1'b0);
    chk("press1_stable", {24'h0, stable}, 32'hFF);
    chk("press1_valid", {31'h0, event_valid}, 32'h0);
    do_poll(32'h0000_00FE, 1'b0);
    chk("press2_stable", {24'h0, stable}, 32'hFE);
    chk("press2_data", {24'h0, event_data}, 32'h01);
    chk("press2_valid", {31'h0, event_valid}, 32'h1);
    exp_q.push_back(8'h01);
    do_poll(32'h0000_00FE, 1'b0);
    chk("held_valid", {31'h0, event_valid}, 32'h1);
    chk("held_data", {24'h0, event_data}, 32'h01);
    accept_one();
    chk("accepted_valid", {31'h0, event_valid}, 32'h0);

    // Release bit0 with upper readdata bits all ones: no event.
    do_poll(32'hFFFF_FFFF, 1'b0);
    do_poll(32'hFFFF_FFFF, 1'b0);
    chk("release_stable", {24'h0, stable}, 32'hFF);
    chk("release_valid", {31'h0, event_valid}, 32'h0);

    // Bounce bit0 for 10 polls: nothing changes.
    for (int i = 0; i < 10; i++) begin
      do_poll((i % 2 == 0) ? 32'h0000_00FE : 32'h0000_00FF, 1'b0);
    end
    chk("bounce_stable", {24'h0, stable}, 32'hFF);
    chk("bounce_valid", {31'h0, event_valid}, 32'h0);
    do_poll(32'h0000_00FE, 1'b0);
    do_poll(32'h0000_00FE, 1'b0);
    chk("settle_data", {24'h0, event_data}, 32'h01);
    exp_q.push_back(8'h01);

    // Bit3 press lands in the same cycle the pending bit0 event is accepted.
    do_poll(32'h0000_00F6, 1'b0);
    do_poll(32'h0000_00F6, 1'b1);
    chk("merge_stable", {24'h0, stable}, 32'hF6);
    chk("merge_data", {24'h0, event_data}, 32'h08);
    chk("merge_valid", {31'h0, event_valid}, 32'h1);
    exp_q.push_back(8'h08);
    accept_one();
    chk("merge_drained", {31'h0, event_valid}, 32'h0);

    // Release everything.
    do_poll(32'hFFFF_FFFF, 1'b0);
    do_poll(32'hFFFF_FFFF, 1'b0);
    chk("release2_stable", {24'h0, stable}, 32'hFF);
    chk("release2_valid", {31'h0, event_valid}, 32'h0);

    // Bit7 press.
    do_poll(32'h0000_007F, 1'b0);
    do_poll(32'h0000_007F, 1'b0);
    chk("b7_data", {24'h0, event_data}, 32'h80);
`ifdef BUTTON_POLLER_IRQ_EN
    chk("b7_irq", {31'h0, irq}, 32'h1);
`endif
    exp_q.push_back(8'h80);
    accept_one();
    chk("b7_accept_valid", {31'h0, event_valid}, 32'h0);
`ifdef BUTTON_POLLER_IRQ_EN
    chk("b7_accept_irq", {31'h0, irq}, 32'h0);
`endif

    // Build up a pending event, then reset in the middle of a capture.
    do_poll(32'h0000_00FF, 1'b0);
    do_poll(32'h0000_00FF, 1'b0);
    do_poll(32'h0000_007F, 1'b0);
    do_poll(32'h0000_007F, 1'b0);
    chk("pre_reset_valid", {31'h0, event_valid}, 32'h1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (avm_read) break;
    end
    chk("reset_read_seen", {31'h0, avm_read}, 32'h1);
    @(posedge clk); #1;
    avm_readdata = 32'h0000_0000;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_avm_read", {31'h0, avm_read}, 32'h0);
    chk("mid_rst_stable", {24'h0, stable}, 32'hFF);
    chk("mid_rst_valid", {31'h0, event_valid}, 32'h0);
    chk("mid_rst_data", {24'h0, event_data}, 32'h0);
`ifdef BUTTON_POLLER_IRQ_EN
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
`endif
    reset = 1'b0;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (avm_read) begin
        first = n;
        break;
      end
    end
    chk("post_rst_first_read", first, POLL_DIV);
    chk("post_rst_stable", {24'h0, stable}, 32'hFF);

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
